// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter sequencing issue/capture/respond accesses to the data memory map.
// Define MM_RANGE_CHECK_EN to reject addresses at or above 0x0860 with err instead of forwarding them.
module data_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_gnt,
    output logic              a_ack,
    output logic [7:0]        a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_gnt,
    output logic              b_ack,
    output logic [7:0]        b_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mm_addr,
    output logic              mm_we,
    output logic [7:0]        mm_data_in,
    output logic              mm_io_only,
    input  logic [7:0]        mm_q
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t state_q, state_d;
    logic owner_q, we_q, io_q, oor_q;
    logic [7:0] wdata_q, rdata_q;
    logic [ADDR_W-1:0] mm_addr_q, sel_addr;
    logic [3:0] starve_q, starve_d;
    logic grant, b_win, is_io, oor_d, issue, resp;
    logic [7:0] rdata;

    assign grant    = (state_q == IDLE) && (a_req || b_req);
    assign b_win    = b_req && (!a_req || starve_q >= 4'(STARVE_LIMIT));
    assign sel_addr = b_win ? b_addr : a_addr;
    assign is_io    = (sel_addr >= ADDR_W'(32'h20)) && (sel_addr < ADDR_W'(32'h60));
`ifdef MM_RANGE_CHECK_EN
    assign oor_d = sel_addr >= ADDR_W'(32'h860);
`else
    assign oor_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE)    ? (grant ? ISSUE : IDLE) :
                  (state_q == ISSUE)   ? CAPTURE :
                  (state_q == CAPTURE) ? RESP : IDLE;
    end

    // Counter only moves in IDLE; it tracks consecutive B losses while both request.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE)
            starve_d = (a_req && b_req && !b_win) ? ((starve_q == 4'hF) ? starve_q : starve_q + 4'd1) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            io_q      <= 1'b0;
            oor_q     <= 1'b0;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            mm_addr_q <= '0;
            starve_q  <= 4'd0;
        end else begin
            starve_q <= starve_d;
            if (grant) begin
                owner_q   <= b_win;
                we_q      <= b_win ? b_we : a_we;
                wdata_q   <= b_win ? b_wdata : a_wdata;
                io_q      <= is_io;
                oor_q     <= oor_d;
                mm_addr_q <= is_io ? sel_addr - ADDR_W'(32'h20) : sel_addr;
            end
            if (state_q == CAPTURE) rdata_q <= mm_q;
        end
    end

    assign issue = state_q == ISSUE;
    assign resp  = state_q == RESP;
    assign rdata = oor_q ? 8'hFF : (we_q ? 8'h00 : rdata_q);

    always_comb begin
        a_gnt      = grant && !b_win;
        b_gnt      = grant && b_win;
        a_ack      = resp && !owner_q;
        b_ack      = resp && owner_q;
        a_rdata    = (resp && !owner_q) ? rdata : 8'h00;
        b_rdata    = (resp && owner_q) ? rdata : 8'h00;
        err        = resp && oor_q;
        mm_addr    = mm_addr_q;
        mm_we      = issue && we_q && !oor_q;
        mm_data_in = issue ? wdata_q : 8'h00;
        mm_io_only = issue && io_q;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of grant, latency, decode, starvation, range check and reset abort.
// Memory map modelled as registered read data mm_q = 0x5A ^ mm_addr[7:0].
module tb_data_mem_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic a_gnt, a_ack, b_gnt, b_ack, err, mm_we, mm_io_only;
    logic [7:0] a_rdata, b_rdata, mm_data_in;
    logic [15:0] mm_addr;
    logic [7:0] mm_q = 8'h00;
    logic [6:0] flags;
    int vectors = 0, errs = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
        .err(err), .mm_addr(mm_addr), .mm_we(mm_we), .mm_data_in(mm_data_in),
        .mm_io_only(mm_io_only), .mm_q(mm_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mm_q <= 8'h5A ^ mm_addr[7:0];
    assign flags = {a_gnt, b_gnt, a_ack, b_ack, err, mm_we, mm_io_only};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        tick(2);
        rst_n = 1'b1;
        tick();
        chk("reset_flags", 16'(flags), 16'h0);
        chk("reset_mm_addr", mm_addr, 16'h0);
        chk("reset_data", {a_rdata, b_rdata}, 16'h0);
        chk("reset_mm_data", 16'(mm_data_in), 16'h0);

        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0100; #1;
        chk("a_rd_gnt", 16'(flags), 16'(7'b1000000));
        tick();
        chk("a_rd_issue_flags", 16'(flags), 16'h0);
        chk("a_rd_issue_addr", mm_addr, 16'h0100);
        tick();
        chk("a_rd_capture_flags", 16'(flags), 16'h0);
        tick();
        chk("a_rd_ack", 16'(flags), 16'(7'b0010000));
        chk("a_rd_rdata", 16'(a_rdata), 16'h5A);
        chk("a_rd_b_rdata", 16'(b_rdata), 16'h0);
        a_req = 1'b0;
        tick();

        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h003F; b_wdata = 8'hC3; #1;
        chk("b_wr_gnt", 16'(flags), 16'(7'b0100000));
        tick();
        chk("b_wr_issue_flags", 16'(flags), 16'(7'b0000011));
        chk("b_wr_issue_addr", mm_addr, 16'h001F);
        chk("b_wr_issue_data", 16'(mm_data_in), 16'hC3);
        tick();
        chk("b_wr_capture_flags", 16'(flags), 16'h0);
        chk("b_wr_capture_data", 16'(mm_data_in), 16'h0);
        chk("b_wr_addr_hold", mm_addr, 16'h001F);
        tick();
        chk("b_wr_ack", 16'(flags), 16'(7'b0001000));
        chk("b_wr_rdata", {a_rdata, b_rdata}, 16'h0);
        b_req = 1'b0; b_we = 1'b0;
        tick();

        a_req = 1'b1; a_addr = 16'h0210; b_req = 1'b1; b_addr = 16'h0321; #1;
        chk("prio_first_gnt", 16'(flags), 16'(7'b1000000));
        tick(3);
        chk("prio_a_ack", 16'(flags), 16'(7'b0010000));
        chk("prio_a_rdata", 16'(a_rdata), 16'h4A);
        a_req = 1'b0;
        tick();
        chk("prio_b_gnt", 16'(flags), 16'(7'b0100000));
        tick();
        chk("prio_b_issue_flags", 16'(flags), 16'h0);
        chk("prio_b_issue_addr", mm_addr, 16'h0321);
        tick(2);
        chk("prio_b_ack", 16'(flags), 16'(7'b0001000));
        chk("prio_b_rdata", 16'(b_rdata), 16'h7B);
        b_req = 1'b0;
        tick();

        a_addr = 16'h0105; b_addr = 16'h0042; a_req = 1'b1; b_req = 1'b1; #1;
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("starve_gnt%0d", r), 16'({a_gnt, b_gnt}), (r == 4) ? 16'h1 : 16'h2);
            tick(3);
            chk($sformatf("starve_ack%0d", r), 16'({a_ack, b_ack}), (r == 4) ? 16'h1 : 16'h2);
            chk($sformatf("starve_rdata%0d", r), (r == 4) ? 16'(b_rdata) : 16'(a_rdata),
                (r == 4) ? 16'h78 : 16'h5F);
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();

        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0860; a_wdata = 8'h11; #1;
        chk("range_gnt", 16'(flags), 16'(7'b1000000));
        tick();
        chk("range_issue_addr", mm_addr, 16'h0860);
`ifdef MM_RANGE_CHECK_EN
        chk("range_issue_flags", 16'(flags), 16'h0);
        tick(2);
        chk("range_ack_err", 16'(flags), 16'(7'b0010100));
        chk("range_rdata", 16'(a_rdata), 16'hFF);
`else
        chk("range_issue_flags", 16'(flags), 16'(7'b0000010));
        tick(2);
        chk("range_ack_err", 16'(flags), 16'(7'b0010000));
        chk("range_rdata", 16'(a_rdata), 16'h0);
`endif
        a_req = 1'b0; a_we = 1'b0;
        tick();

        a_req = 1'b1; a_addr = 16'h0100; #1;
        chk("rst_mid_gnt", 16'(flags), 16'(7'b1000000));
        tick(2);
        rst_n = 1'b0; a_req = 1'b0;
        tick();
        chk("rst_mid_flags", 16'(flags), 16'h0);
        chk("rst_mid_mm_addr", mm_addr, 16'h0);
        chk("rst_mid_rdata", {a_rdata, b_rdata}, 16'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_no_ack", 16'(flags), 16'h0);
        a_req = 1'b1; #1;
        chk("rst_mid_regnt", 16'(flags), 16'(7'b1000000));
        tick(3);
        chk("rst_mid_ack", 16'(flags), 16'(7'b0010000));
        chk("rst_mid_rdata2", 16'(a_rdata), 16'h5A);
        a_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Arbitrates single-port access to the data memory map (register file 0x0000–0x001F, IO 0x0020–0x005F, SRAM 0x0060–0x085F) between two requesters.
- Port A is the core LD/ST/stack path. Port B is the program loader/debug path.
- Sequences each access as a fixed 3-state transaction (issue, capture, respond) to absorb the memory map's registered one-cycle read latency.
- Sits between the requesters and the memory map; it is the only driver of the memory map's address, WE, data_in and IO_only inputs.

Parameters:
- ADDR_W, 16, requester and memory-map address width.
- STARVE_LIMIT, 4, consecutive port-B losses after which port B wins the next arbitration; range 1–15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- a_req  in  1  port A request.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  8  port A write data.
- a_gnt  out  1  one-cycle pulse: port A request latched.
- a_ack  out  1  one-cycle pulse: port A transaction complete.
- a_rdata  out  8  port A read data, valid while a_ack=1.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_ack, b_rdata: same as port A, for port B.
- err  out  1  one-cycle pulse with ack when the granted address was out of range.
- mm_addr  out  16  memory map address.
- mm_we  out  1  memory map write enable.
- mm_data_in  out  8  memory map write data.
- mm_io_only  out  1  memory map IO_only select.
- mm_q  in  8  memory map registered read data.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All outputs 0; mm_addr=0; starvation counter=0.
  - Any in-flight transaction is aborted with no ack.
  - rst_n has no effect between clock edges.
- States:
  - IDLE: no transaction in progress; arbitration happens here.
  - ISSUE: memory map is driven for exactly one cycle.
  - CAPTURE: mm_q is sampled into the internal read-data register.
  - RESP: ack is pulsed to the owning port.
- Transitions: IDLE→ISSUE on any sampled request; ISSUE→CAPTURE→RESP→IDLE unconditionally.
- Arbitration:
  - Evaluated only in IDLE, on the current req levels.
  - Port A wins by default.
  - Port B wins if a_req=0, or if the starvation counter is ≥ STARVE_LIMIT.
  - Starvation counter: increments (saturating at 15) when both ports request and A wins; clears when B is granted or b_req=0 in IDLE.
- Grant:
  - On the IDLE→ISSUE edge, the winner's we/addr/wdata are latched and its gnt pulses for that one cycle (the IDLE cycle).
  - Requesters hold req high until ack; inputs may change after gnt.
  - Dropping req after gnt does not cancel the transaction.
  - A req still high in the cycle after ack (back in IDLE) is treated as a new request.
- Latency:
  - Request sampled in IDLE at cycle N → mm signals in cycle N+1 → capture in N+2 → ack in N+3.
  - Next grant no earlier than N+4.
  - Same latency for reads and writes; throughput is one transaction per 4 cycles.
- Address decode, on the latched address:
  - 0x0000–0x001F: mm_addr=addr, mm_io_only=0.
  - 0x0020–0x005F: mm_addr=addr−0x20 (IO index 0–63), mm_io_only=1.
  - 0x0060–0x085F: mm_addr=addr, mm_io_only=0.
- ISSUE drives:
  - mm_we=we, mm_data_in=wdata.
  - mm_we is 0 in every other state and never asserted twice per transaction.
- Outside ISSUE: mm_addr holds its last value; mm_io_only=0; mm_data_in=0.
- Read data:
  - rdata of the owning port = captured mm_q during its ack cycle, 0x00 otherwise.
  - For writes, rdata=0x00.
  - The non-owning port's ack, gnt and rdata stay 0.
- Simultaneous events: both requests in the same IDLE cycle → exactly one gnt; the loser is served next IDLE if it still requests.

Optional Feature:
- MM_RANGE_CHECK_EN defined:
  - Latched address ≥ 0x0860 is out of range.
  - ISSUE cycle runs with mm_we forced to 0.
  - RESP pulses ack and err together; rdata=0xFF.
- Undefined:
  - No check is made and err is tied 0.
  - Address is forwarded unchanged with mm_io_only=0.

Test Plan:
- Reset mid-transaction:
  - Stimulus: a_req read 0x0100, then rst_n=0 during CAPTURE.
  - Required: no a_ack; all outputs 0 next cycle; new a_req after release granted normally.
- Port A SRAM read:
  - Stimulus: a_req, a_we=0, a_addr=0x0100, model mm_q=0x5A.
  - Required: a_gnt at N; mm_addr=0x0100, mm_io_only=0, mm_we=0 at N+1; a_ack with a_rdata=0x5A at N+3.
- Port B IO write:
  - Stimulus: b_req, b_we=1, b_addr=0x003F, b_wdata=0xC3.
  - Required: mm_addr=0x001F, mm_io_only=1, mm_we=1, mm_data_in=0xC3 for exactly one cycle; b_ack at N+3; b_rdata=0x00.
- Fixed priority:
  - Stimulus: a_req and b_req in the same cycle, each held until its ack.
  - Required: A granted first; B granted at N+4; no overlapping mm_we.
- Starvation:
  - Stimulus: A re-requests every IDLE, b_req held constantly, STARVE_LIMIT=4.
  - Required: A wins 4 times; the 5th grant goes to B; counter clears; A wins the 6th.
- Range check (MM_RANGE_CHECK_EN defined):
  - Stimulus: a_we=1, a_addr=0x0860.
  - Required: mm_we stays 0; a_ack and err pulse together at N+3; a_rdata=0xFF.
  - Without the macro: mm_we=1 at mm_addr=0x0860; err stays 0.
